// File: rtl/controlador_irrigacao_if.sv
// Mode/timer link between the irrigation sequencer (master) and the
// countdown timer (slave): mode requests out, expiry flag back.
interface controlador_irrigacao_if;
    logic aspersao;
    logic gotejamento;
    logic tempoZerado;

    modport master (output aspersao, output gotejamento, input tempoZerado);
    modport slave  (input aspersao, input gotejamento, output tempoZerado);
endinterface

// File: rtl/controlador_irrigacao.sv
// Irrigation sequencer: filters the soil-dryness sensor, decodes the tank
// level, picks sprinkler or drip mode, drives the timer mode lines, valves
// and pump, rests between cycles and raises an alarm on faults.
module controlador_irrigacao #(
    parameter int unsigned FILTRO_SEG   = 3,
    parameter int unsigned REPOUSO_SEG  = 60,
    parameter int unsigned WATCHDOG_SEG = 1900
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   umSegundo,
    input  logic                   soloSeco,
    input  logic [2:0]             nivelDagua,
    input  logic                   reconhecer,
    controlador_irrigacao_if.master tmr,
    output logic                   valvulaAspersor,
    output logic                   valvulaGotejador,
    output logic                   bomba,
    output logic                   alarme,
    output logic [2:0]             estado
);

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        VERIFICA    = 3'd1,
        ASPERSAO    = 3'd2,
        GOTEJAMENTO = 3'd3,
        REPOUSO     = 3'd4,
        ALARME      = 3'd5
    } estado_t;

    localparam logic [3:0]  FILTRO_MAX   = 4'(FILTRO_SEG);
    localparam logic [7:0]  REPOUSO_MAX  = 8'(REPOUSO_SEG);
    localparam logic [10:0] WATCHDOG_MAX = 11'(WATCHDOG_SEG);

    estado_t     r_estado;
    estado_t     w_prox;
    logic [3:0]  r_filtro;
    logic [7:0]  r_repouso;
    logic [10:0] r_watchdog;
    logic        r_armado;
    logic        r_aspersao;
    logic        r_gotejamento;
    logic        r_valvulaAspersor;
    logic        r_valvulaGotejador;
    logic        r_bomba;
    logic        r_alarme;

    logic w_vazio;
    logic w_baixo;
    logic w_medio;
    logic w_cheio;
    logic w_falha;
    logic w_nivelRuim;
    logic w_secoEstavel;
    logic w_irrigando;
    logic w_entraIrrigacao;
    logic w_entraRepouso;

    // Tank level decode (thermometer code; any other pattern is a sensor fault)
    always_comb begin
        w_vazio     = (nivelDagua == 3'b000);
        w_baixo     = (nivelDagua == 3'b001);
        w_medio     = (nivelDagua == 3'b011);
        w_cheio     = (nivelDagua == 3'b111);
        w_falha     = !(w_vazio || w_baixo || w_medio || w_cheio);
        w_nivelRuim = w_vazio || w_falha;
    end

    assign w_secoEstavel    = (r_filtro == FILTRO_MAX);
    assign w_irrigando      = (r_estado == ASPERSAO) || (r_estado == GOTEJAMENTO);
    assign w_entraIrrigacao = ((w_prox == ASPERSAO) || (w_prox == GOTEJAMENTO)) &&
                              (w_prox != r_estado);
    assign w_entraRepouso   = (w_prox == REPOUSO) && (r_estado != REPOUSO);

    // Next-state selection
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (w_nivelRuim)        w_prox = ALARME;
                else if (w_secoEstavel) w_prox = VERIFICA;
            end
            VERIFICA: begin
                if (w_medio || w_cheio) w_prox = ASPERSAO;
                else if (w_baixo)       w_prox = GOTEJAMENTO;
                else                    w_prox = ALARME;
            end
            ASPERSAO, GOTEJAMENTO: begin
                if (w_nivelRuim)                          w_prox = ALARME;
                else if (r_watchdog == WATCHDOG_MAX)      w_prox = ALARME;
                else if (r_armado && tmr.tempoZerado)     w_prox = REPOUSO;
            end
            REPOUSO: begin
                if (w_nivelRuim)                    w_prox = ALARME;
                else if (r_repouso == REPOUSO_MAX)  w_prox = OCIOSO;
            end
            ALARME: begin
                if (reconhecer && !w_nivelRuim) w_prox = OCIOSO;
            end
            default: w_prox = OCIOSO;
        endcase
    end

    // State register and outputs; outputs are registered from the next state
    // so they change on the same edge as estado
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_estado           <= OCIOSO;
            r_aspersao         <= 1'b0;
            r_gotejamento      <= 1'b0;
            r_valvulaAspersor  <= 1'b0;
            r_valvulaGotejador <= 1'b0;
            r_bomba            <= 1'b0;
            r_alarme           <= 1'b0;
        end else begin
            r_estado           <= w_prox;
            r_aspersao         <= (w_prox == ASPERSAO);
            r_gotejamento      <= (w_prox == GOTEJAMENTO);
            r_valvulaAspersor  <= (w_prox == ASPERSAO);
            r_valvulaGotejador <= (w_prox == GOTEJAMENTO);
            r_bomba            <= (w_prox == ASPERSAO);
            r_alarme           <= (w_prox == ALARME);
        end
    end

    // Dry-soil filter: counts consecutive ticks, saturating at FILTRO_SEG
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_filtro <= '0;
        end else if (!soloSeco || w_entraRepouso) begin
            r_filtro <= '0;
        end else if (umSegundo && (r_filtro != FILTRO_MAX)) begin
            r_filtro <= r_filtro + 4'd1;
        end
    end

    // Watchdog: ticks spent in an irrigation state, saturating at WATCHDOG_SEG
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_watchdog <= '0;
        end else if (w_entraIrrigacao) begin
            r_watchdog <= '0;
        end else if (w_irrigando && umSegundo && (r_watchdog != WATCHDOG_MAX)) begin
            r_watchdog <= r_watchdog + 11'd1;
        end
    end

    // Arm flag: tempoZerado only qualifies after the timer has left 00:00 once
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_armado <= 1'b0;
        end else if (w_entraIrrigacao) begin
            r_armado <= 1'b0;
        end else if (w_irrigando && !tmr.tempoZerado) begin
            r_armado <= 1'b1;
        end
    end

    // Rest interval counter, saturating at REPOUSO_SEG
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_repouso <= '0;
        end else if (w_entraRepouso) begin
            r_repouso <= '0;
        end else if ((r_estado == REPOUSO) && umSegundo && (r_repouso != REPOUSO_MAX)) begin
            r_repouso <= r_repouso + 8'd1;
        end
    end

    assign tmr.aspersao     = r_aspersao;
    assign tmr.gotejamento  = r_gotejamento;
    assign valvulaAspersor  = r_valvulaAspersor;
    assign valvulaGotejador = r_valvulaGotejador;
    assign bomba            = r_bomba;
    assign alarme           = r_alarme;
    assign estado           = r_estado;

endmodule
